// File: rtl/ddr3_zero_init_seq.sv
// ddr3_zero_init_seq: AXI4 write master that zero-fills a fixed DDR3 region once MIG calibration completes.
module ddr3_zero_init_seq #(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter logic [AXI_ID_WIDTH-1:0]   AXI_ID         = '0,
  parameter int                        BURST_LEN      = 16,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 'h8000_0000,
  parameter longint unsigned           SIZE_BYTES     = 65536
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        calib_done_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o
);
  localparam longint unsigned BURST_BYTES = 64'(BURST_LEN) * 64'(AXI_DATA_WIDTH) / 64'd8;
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_STEP = AXI_ADDR_WIDTH'(BURST_BYTES);
  // Start address of the final burst; reaching it in B means the region is covered.
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + AXI_ADDR_WIDTH'(SIZE_BYTES - BURST_BYTES);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
    $error("BURST_LEN must be in 1..256");
  end
  if (AXI_DATA_WIDTH < 8 || (AXI_DATA_WIDTH & (AXI_DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("AXI_DATA_WIDTH must be a power of 2 and at least 8");
  end
  if (BURST_BYTES > 4096) begin : g_bad_4k
    $error("burst crosses a 4KB boundary");
  end
  if (BASE_ADDR % BURST_STEP != '0) begin : g_bad_base
    $error("BASE_ADDR not aligned to burst bytes");
  end
  if (SIZE_BYTES == 0 || SIZE_BYTES % BURST_BYTES != 0) begin : g_bad_size
    $error("SIZE_BYTES must be a nonzero multiple of burst bytes");
  end

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
  state_t                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]                  beat_q;

  assign aw_id_o    = AXI_ID;
  assign aw_addr_o  = addr_q;
  assign aw_len_o   = LAST_BEAT;
  assign aw_size_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign aw_burst_o = 2'b01;
  assign w_data_o   = '0;
  assign w_strb_o   = '1;
  assign w_last_o   = w_valid_o && beat_q == LAST_BEAT;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= BASE_ADDR;
      beat_q     <= '0;
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      b_ready_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (calib_done_i) begin
          state_q    <= AW;
          aw_valid_o <= 1'b1;
          busy_o     <= 1'b1;
        end
        AW: if (aw_ready_i) begin
          state_q    <= W;
          aw_valid_o <= 1'b0;
          w_valid_o  <= 1'b1;
          beat_q     <= '0;
        end
        W: if (w_ready_i) begin
          beat_q <= beat_q + 8'd1;
          if (beat_q == LAST_BEAT) begin
            state_q   <= B;
            w_valid_o <= 1'b0;
            b_ready_o <= 1'b1;
          end
        end
        B: if (b_valid_i) begin
          b_ready_o <= 1'b0;
          if (b_resp_i != 2'b00 || b_id_i != AXI_ID) error_o <= 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_q <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            addr_q     <= addr_q + BURST_STEP;
            state_q    <= AW;
            aw_valid_o <= 1'b1;
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_zero_init_seq.sv
// tb_ddr3_zero_init_seq: directed bench for the zero-fill sequencer (4-burst region plus a single-beat region).
module tb_ddr3_zero_init_seq;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic        rst_n = 0;
  logic        a_calib = 0, z_calib = 0;
  logic        a_busy, a_done, a_err, z_busy, z_done, z_err;
  logic [3:0]  a_aw_id, z_aw_id;
  logic [63:0] a_aw_addr, z_aw_addr;
  logic [7:0]  a_aw_len, z_aw_len;
  logic [2:0]  a_aw_size, z_aw_size;
  logic [1:0]  a_aw_burst, z_aw_burst;
  logic        a_aw_valid, z_aw_valid;
  logic        a_aw_ready = 0, z_aw_ready = 0;
  logic [63:0] a_w_data, z_w_data;
  logic [7:0]  a_w_strb, z_w_strb;
  logic        a_w_last, z_w_last, a_w_valid, z_w_valid;
  logic        a_w_ready = 0, z_w_ready = 0;
  logic [3:0]  a_b_id = 0, z_b_id = 0;
  logic [1:0]  a_b_resp = 0, z_b_resp = 0;
  logic        a_b_valid = 0, z_b_valid = 0;
  logic        a_b_ready, z_b_ready;

  ddr3_zero_init_seq #(.BURST_LEN(16), .BASE_ADDR(64'h8000_0000), .SIZE_BYTES(512)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .calib_done_i(a_calib),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_err),
    .aw_id_o(a_aw_id), .aw_addr_o(a_aw_addr), .aw_len_o(a_aw_len), .aw_size_o(a_aw_size),
    .aw_burst_o(a_aw_burst), .aw_valid_o(a_aw_valid), .aw_ready_i(a_aw_ready),
    .w_data_o(a_w_data), .w_strb_o(a_w_strb), .w_last_o(a_w_last), .w_valid_o(a_w_valid),
    .w_ready_i(a_w_ready), .b_id_i(a_b_id), .b_resp_i(a_b_resp), .b_valid_i(a_b_valid),
    .b_ready_o(a_b_ready)
  );

  ddr3_zero_init_seq #(.BURST_LEN(1), .BASE_ADDR(64'h8000_0000), .SIZE_BYTES(8)) u_z (
    .clk_i(clk), .rst_ni(rst_n), .calib_done_i(z_calib),
    .busy_o(z_busy), .done_o(z_done), .error_o(z_err),
    .aw_id_o(z_aw_id), .aw_addr_o(z_aw_addr), .aw_len_o(z_aw_len), .aw_size_o(z_aw_size),
    .aw_burst_o(z_aw_burst), .aw_valid_o(z_aw_valid), .aw_ready_i(z_aw_ready),
    .w_data_o(z_w_data), .w_strb_o(z_w_strb), .w_last_o(z_w_last), .w_valid_o(z_w_valid),
    .w_ready_i(z_w_ready), .b_id_i(z_b_id), .b_resp_i(z_b_resp), .b_valid_i(z_b_valid),
    .b_ready_o(z_b_ready)
  );

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    a_b_valid = 0; a_aw_ready = 0; a_w_ready = 0; a_calib = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // Acts as the slave for u_a over one full 4-burst fill; B arrives 2 cycles after the last beat.
  task automatic run_fill(input int bp, input int bad, input string tag);
    int aw_cnt = 0, w_hs = 0, beat = 0, b_cnt = 0, b_wait = 0, cyc = 0, viol = 0, err_early = 0;
    logic [63:0] exp_addr = BASE;
    logic aw_stall = 0, w_stall = 0, b_fire = 0;
    a_calib = 1;
    while (!a_done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (b_fire) begin
        b_fire = 0; a_b_valid = 0; b_cnt++;
        if (b_cnt - 1 == bad) check(a_err, 1, {tag, "_err_next_cycle"});
      end
      if (a_err && (bad < 0 || b_cnt <= bad)) err_early++;
      if (aw_stall && !a_aw_valid) viol++;
      if (w_stall && !a_w_valid) viol++;
      if (a_aw_valid && a_w_valid) viol++;
      if (!a_busy && !a_done) viol++;
      if (a_aw_valid && (a_aw_addr !== exp_addr || a_aw_len !== 8'd15 || a_aw_size !== 3'd3 ||
                         a_aw_burst !== 2'b01 || a_aw_id !== 4'd0)) viol++;
      if (a_w_valid && (aw_cnt <= w_hs / 16 || a_w_data !== 64'd0 || a_w_strb !== 8'hff ||
                        a_w_last !== (beat == 15))) viol++;
      a_aw_ready = ($urandom_range(99) >= bp);
      a_w_ready  = ($urandom_range(99) >= bp);
      aw_stall = a_aw_valid && !a_aw_ready;
      w_stall  = a_w_valid && !a_w_ready;
      if (a_aw_valid && a_aw_ready) begin aw_cnt++; exp_addr += 64'h80; end
      if (a_w_valid && a_w_ready) begin
        w_hs++;
        if (beat == 15) begin beat = 0; b_wait = 3; end else beat++;
      end
      if (b_wait > 0) begin
        b_wait--;
        if (b_wait == 0) begin a_b_valid = 1; a_b_resp = (b_cnt == bad) ? 2'b10 : 2'b00; end
      end
      if (a_b_valid && a_b_ready) b_fire = 1;
    end
    a_aw_ready = 0; a_w_ready = 0; a_b_valid = 0;
    check(a_done, 1, {tag, "_done"});
    check(a_busy, 0, {tag, "_busy_after"});
    check(aw_cnt, 4, {tag, "_aw_count"});
    check(w_hs, 64, {tag, "_w_count"});
    check(b_cnt, 4, {tag, "_b_count"});
    check(viol, 0, {tag, "_protocol"});
    check(err_early, 0, {tag, "_err_early"});
    check(a_err, (bad >= 0), {tag, "_err_final"});
  endtask

  initial begin
    int idle_viol = 0, n = 0, found;
    // reset state
    repeat (2) @(negedge clk);
    check({a_aw_valid, a_w_valid, a_b_ready, a_busy, a_done, a_err}, 0, "reset_outputs");
    check(a_aw_addr, BASE, "reset_addr");
    rst_n = 1;
    // calibration not done: nothing moves
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_aw_valid || a_w_valid || a_b_ready || a_busy || a_done) idle_viol++;
    end
    check(idle_viol, 0, "idle_no_calib");

    // zero backpressure; then calib drop after done
    run_fill(0, -1, "plain");
    a_calib = 0;
    repeat (5) @(negedge clk);
    check({a_done, a_aw_valid, a_busy}, 3'b100, "a_calib_drop_after_done");

    do_reset();
    check({a_done, a_err, a_busy}, 0, "reset_clears_sticky");
    run_fill(30, -1, "backpressure");

    do_reset();
    run_fill(0, 1, "bad_resp");

    // reset during beat 7 of the first burst
    do_reset();
    a_calib = 1; a_aw_ready = 1; a_w_ready = 1;
    for (int i = 0; i < 200 && n < 6; i++) begin
      @(negedge clk);
      if (a_w_valid && a_w_ready) n++;
    end
    @(posedge clk);
    #2;
    check({a_w_valid, a_w_last}, 2'b10, "mid_burst_before_reset");
    rst_n = 0;
    #1;
    check({a_aw_valid, a_w_valid, a_w_last, a_b_ready, a_busy, a_done, a_err}, 0, "async_reset_outputs");
    @(negedge clk);
    rst_n = 1;
    run_fill(0, -1, "restart");

    // single-beat region
    z_aw_ready = 1; z_w_ready = 1; z_b_valid = 1;
    z_calib = 1;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (z_aw_valid) found = 1;
    end
    check(found, 1, "z_aw_seen");
    check({z_aw_addr, z_aw_len, z_aw_size}, {BASE, 8'd0, 3'd3}, "z_aw_fields");
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (z_w_valid) found = 1;
    end
    check({found[0], z_w_last}, 2'b11, "z_w_last");
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (z_done) found = 1;
    end
    check({found[0], z_err, z_busy}, 3'b100, "z_done");
    z_calib = 0;
    repeat (5) @(negedge clk);
    check({z_done, z_aw_valid, z_w_valid}, 3'b100, "z_calib_drop_after_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
